// File: rtl/fetch_pkg.sv
// Shared types and the opcode length decode for the fetch/decode pair.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    PRESENT  = 2'd3
  } state_t;

  localparam logic [7:0] OPC_JSR = 8'h20;

  // Instruction length in bytes (1..3) from the opcode alone.
  // cc = opcode[1:0] selects the opcode group, bbb = opcode[4:2] the addressing form.
  function automatic logic [1:0] instr_length(input logic [7:0] opcode);
    logic [1:0] cc;
    logic [2:0] bbb;
    logic [1:0] len;
    cc  = opcode[1:0];
    bbb = opcode[4:2];
    len = 2'd1;
    if (opcode == OPC_JSR) begin
      // JSR sits in an otherwise one-byte slot but carries an absolute address.
      len = 2'd3;
    end else begin
      case (cc)
        2'b01: len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
        2'b11: len = 2'd1;
        default: begin
          case (bbb)
            3'b000:                 len = opcode[7] ? 2'd2 : 2'd1;
            3'b001, 3'b100, 3'b101: len = 2'd2;
            3'b010, 3'b110:         len = 2'd1;
            default:                len = 2'd3;  // 011, 111
          endcase
        end
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/fetch_length_lut.sv
// Combinational opcode-to-length lookup, shared with the decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: opcode (in, 8) -> len (out, 2) in bytes, 1..3.
module fetch_length_lut
  import fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  assign len = instr_length(opcode);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks pc, reads opcode/operand bytes over req/ack, presents a bundle to the decoder.
// Latency: n-byte instruction valid n cycles after entering FETCH_OP with ack tied high; n+1 cycles/instr
//          (n cycles/instr when built with PREFETCH_EN, which adds a one-byte opcode prefetch register).
// Backpressure: bundle held stable while instr_valid && !instr_ready; no memory request while stalled
//          (except the single prefetch read under PREFETCH_EN). flush overrides everything.
// Ports: clk_2/rst (async, active-high); flush/flush_addr redirect; mem_req/mem_addr/mem_ack/mem_rdata
//        memory read; instr_valid/instr_ready + instruction/operand_lo/operand_hi/instr_len/instr_pc bundle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_2,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instruction,
  output logic [7:0]        operand_lo,
  output logic [7:0]        operand_hi,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              req_en;     // holds mem_req low through reset and the first edge after it
  logic              acked;
  logic              cap_op, cap_lo, cap_hi;
  logic              valid_nxt;
  logic [7:0]        op_src;
  logic [1:0]        len_new;

`ifdef PREFETCH_EN
  logic       pf_valid;
  logic [7:0] pf_data;
  logic       pf_load, pf_clr;

  // A buffered opcode wins over the bus; pf_valid implies no read is outstanding.
  assign op_src = pf_valid ? pf_data : mem_rdata;
`else
  assign op_src = mem_rdata;
`endif

  fetch_length_lut u_len (
    .opcode (op_src),
    .len    (len_new)
  );

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) state <= FETCH_OP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = instr_valid;
    cap_op    = 1'b0;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
`ifdef PREFETCH_EN
    pf_load   = 1'b0;
    pf_clr    = 1'b0;
    mem_req   = req_en && ((state != PRESENT) || !pf_valid);
`else
    mem_req   = req_en && (state != PRESENT);
`endif
    mem_addr  = pc;
    acked     = mem_req && mem_ack;

    if (flush) begin
      // Abandon any read and drop any pending bundle, even one being accepted this edge.
      state_nxt = FETCH_OP;
      pc_nxt    = flush_addr;
      valid_nxt = 1'b0;
`ifdef PREFETCH_EN
      pf_clr    = 1'b1;
`endif
    end else begin
      case (state)
        FETCH_OP: begin
          if (acked) begin
            cap_op    = 1'b1;
            pc_nxt    = pc + PC_INC;
            state_nxt = (len_new == 2'd1) ? PRESENT : FETCH_LO;
            valid_nxt = (len_new == 2'd1);
          end
        end
        FETCH_LO: begin
          if (acked) begin
            cap_lo    = 1'b1;
            pc_nxt    = pc + PC_INC;
            state_nxt = (instr_len == 2'd3) ? FETCH_HI : PRESENT;
            valid_nxt = (instr_len != 2'd3);
          end
        end
        FETCH_HI: begin
          if (acked) begin
            cap_hi    = 1'b1;
            pc_nxt    = pc + PC_INC;
            state_nxt = PRESENT;
            valid_nxt = 1'b1;
          end
        end
        PRESENT: begin
          if (instr_ready) begin
            valid_nxt = 1'b0;
            state_nxt = FETCH_OP;
`ifdef PREFETCH_EN
            // Next opcode already in hand (buffered or arriving now): skip FETCH_OP.
            if (pf_valid || acked) begin
              cap_op    = 1'b1;
              pf_clr    = 1'b1;
              pc_nxt    = pc + PC_INC;
              state_nxt = (len_new == 2'd1) ? PRESENT : FETCH_LO;
              valid_nxt = (len_new == 2'd1);
            end
`endif
          end
`ifdef PREFETCH_EN
          else if (acked) begin
            // pc is not advanced here: the buffered byte still lives at pc.
            pf_load = 1'b1;
          end
`endif
        end
        default: state_nxt = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_en      <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= 8'h00;
      operand_lo  <= 8'h00;
      operand_hi  <= 8'h00;
      instr_len   <= 2'd1;
      instr_pc    <= RESET_PC;
    end else begin
      req_en      <= 1'b1;
      pc          <= pc_nxt;
      instr_valid <= valid_nxt;
      if (cap_op) begin
        instruction <= op_src;
        operand_lo  <= 8'h00;
        operand_hi  <= 8'h00;
        instr_len   <= len_new;
        instr_pc    <= pc;
      end
      if (cap_lo) operand_lo <= mem_rdata;
      if (cap_hi) operand_hi <= mem_rdata;
    end
  end

`ifdef PREFETCH_EN
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      pf_valid <= 1'b0;
      pf_data  <= 8'h00;
    end else if (pf_clr) begin
      pf_valid <= 1'b0;
    end else if (pf_load) begin
      pf_valid <= 1'b1;
      pf_data  <= mem_rdata;
    end
  end
`endif

endmodule
